// File: rtl/axis_packet_arbiter_pkg.sv
// Shared definitions for the packet arbiter slice.
//   state_e        : FSM encoding (IDLE=0, XFER=1)
//   onehot_to_idx  : one-hot grant vector to binary index
//   rr_search      : round-robin first-requester search over n sources
package axis_packet_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  localparam int unsigned MAX_N = 16;
  localparam int unsigned IDX_W = 4;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  // Returns {found, index}: first set req bit in the order ptr, ptr+1, ... n-1, 0, ... ptr-1.
  function automatic logic [IDX_W:0] rr_search(input logic [MAX_N-1:0] req,
                                               input logic [IDX_W-1:0] ptr,
                                               input int unsigned n);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        cand = IDX_W'((32'(ptr) + i) % n);
        if (!found && req[cand]) begin
          found = 1'b1;
          idx   = cand;
        end
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/axis_packet_arbiter_rr_select.sv
// Combinational round-robin selector.
//   req_i   : request vector, one bit per source
//   ptr_i   : highest-priority source index
//   grant_o : one-hot winner (zero when no request)
//   valid_o : at least one request present
module axis_packet_arbiter_rr_select
  import axis_packet_arbiter_pkg::*;
#(
  parameter  int unsigned N  = 2,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic          valid_o
);

  logic [IDX_W:0] pick;

  always_comb begin
    pick    = rr_search(MAX_N'(req_i), IDX_W'(ptr_i), N);
    valid_o = pick[IDX_W];
    grant_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      grant_o[k] = pick[IDX_W] && (pick[IDX_W-1:0] == IDX_W'(k));
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream-style sink among N sources.
//   i_clk, i_rst_n          : clock, synchronous active-low reset
//   i_data/i_last/i_valid   : per-source beats (source k at i_data[k*DW +: DW])
//   o_ready                 : per-source ready, only the owner's bit follows i_ready
//   o_data/o_last/o_valid   : muxed beat to the sink; i_ready is the sink ready
//   o_grant                 : one-hot current owner, zero when idle
//   o_busy                  : a packet is owned
//   o_pkt_cnt               : completed packets, wraps modulo 2^CW
module axis_packet_arbiter
  import axis_packet_arbiter_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N*DW-1:0] i_data,
  input  logic [N-1:0]    i_last,
  input  logic [N-1:0]    i_valid,
  output logic [N-1:0]    o_ready,
  output logic [DW-1:0]   o_data,
  output logic            o_last,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [N-1:0]    o_grant,
  output logic            o_busy,
  output logic [CW-1:0]   o_pkt_cnt
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  state_e           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [N-1:0]     rr_grant;
  logic             rr_valid;
  logic [DW-1:0]    data_sel;
  logic             last_sel;
  logic             valid_sel;
  logic [IDX_W-1:0] own_idx;
  logic [PW-1:0]    ptr_next;

  axis_packet_arbiter_rr_select #(.N(N)) u_rr_select (
    .req_i   (i_valid),
    .ptr_i   (ptr_q),
    .grant_o (rr_grant),
    .valid_o (rr_valid)
  );

  // One-hot mux driven straight from the registered grant; zero when idle.
  always_comb begin
    data_sel  = '0;
    last_sel  = 1'b0;
    valid_sel = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (grant_q[k]) begin
        data_sel  = i_data[k*DW +: DW];
        last_sel  = i_last[k];
        valid_sel = i_valid[k];
      end
    end
  end

  // Owner just finished becomes lowest priority next time.
  always_comb begin
    own_idx = onehot_to_idx(MAX_N'(grant_q));
    if (N == 1 || own_idx == IDX_W'(N - 1)) ptr_next = '0;
    else                                    ptr_next = PW'(own_idx + IDX_W'(1));
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    o_valid = 1'b0;
    o_ready = '0;
    o_data  = data_sel;
    o_last  = last_sel;
    unique case (state_q)
      IDLE: begin
        if (rr_valid) begin
          grant_d = rr_grant;
          state_d = XFER;
        end
      end
      XFER: begin
        o_valid = valid_sel;
        o_ready = grant_q & {N{i_ready}};
        if (valid_sel && i_ready && last_sel) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = ptr_next;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_grant   = grant_q;
  assign o_busy    = (state_q == XFER);
  assign o_pkt_cnt = cnt_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Bench for axis_packet_arbiter: one N=2/CW=16 instance (u0) and one N=4/CW=2 instance (u1),
// checked every cycle against a packet-level ownership model plus directed literal expectations.
module tb_axis_packet_arbiter;

  logic i_clk;
  logic rst_n;

  logic [15:0] a_data;
  logic [1:0]  a_last, a_valid, a_ordy, a_grant;
  logic        a_ready_in, a_olast, a_ovalid, a_busy;
  logic [7:0]  a_odata;
  logic [15:0] a_cnt;

  logic [31:0] b_data;
  logic [3:0]  b_last, b_valid, b_ordy, b_grant;
  logic        b_ready_in, b_olast, b_ovalid, b_busy;
  logic [7:0]  b_odata;
  logic [1:0]  b_cnt;

  axis_packet_arbiter #(.N(2), .DW(8), .CW(16)) u0 (
    .i_clk(i_clk), .i_rst_n(rst_n), .i_data(a_data), .i_last(a_last), .i_valid(a_valid),
    .o_ready(a_ordy), .o_data(a_odata), .o_last(a_olast), .o_valid(a_ovalid),
    .i_ready(a_ready_in), .o_grant(a_grant), .o_busy(a_busy), .o_pkt_cnt(a_cnt)
  );

  axis_packet_arbiter #(.N(4), .DW(8), .CW(2)) u1 (
    .i_clk(i_clk), .i_rst_n(rst_n), .i_data(b_data), .i_last(b_last), .i_valid(b_valid),
    .o_ready(b_ordy), .o_data(b_odata), .o_last(b_olast), .o_valid(b_ovalid),
    .i_ready(b_ready_in), .o_grant(b_grant), .o_busy(b_busy), .o_pkt_cnt(b_cnt)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int checks = 0;
  int failures = 0;

  // Source beat queues {last, data}; index = inst*4 + source.
  logic [8:0] srcq[8][$];
  // Accepted beats seen at the sink: src*512 + last*256 + data.
  int logq[2][$];
  bit pop_req[8];

  // Model: owner (-1 = idle), priority pointer, packet count.
  int m_own[2] = '{-1, -1};
  int m_ptr[2] = '{0, 0};
  int m_cnt[2] = '{0, 0};
  int m_n[2]   = '{2, 4};
  int m_mod[2] = '{65536, 4};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < 2; k++) begin
      a_valid[k] = (srcq[k].size() != 0);
      {a_last[k], a_data[k*8 +: 8]} = (srcq[k].size() != 0) ? srcq[k][0] : 9'h0;
    end
    for (int k = 0; k < 4; k++) begin
      b_valid[k] = (srcq[4+k].size() != 0);
      {b_last[k], b_data[k*8 +: 8]} = (srcq[4+k].size() != 0) ? srcq[4+k][0] : 9'h0;
    end
  endtask

  task automatic get_in(input int i, output logic [3:0] v, output logic [3:0] l,
                        output logic [31:0] d, output logic r);
    if (i == 0) begin
      v = {2'b0, a_valid}; l = {2'b0, a_last}; d = {16'h0, a_data}; r = a_ready_in;
    end else begin
      v = b_valid; l = b_last; d = b_data; r = b_ready_in;
    end
  endtask

  task automatic get_out(input int i, output logic [3:0] g, output logic [3:0] rd,
                         output logic [7:0] dt, output logic lt, output logic vl,
                         output logic bs, output int cn);
    if (i == 0) begin
      g = {2'b0, a_grant}; rd = {2'b0, a_ordy}; dt = a_odata; lt = a_olast;
      vl = a_ovalid; bs = a_busy; cn = int'(a_cnt);
    end else begin
      g = b_grant; rd = b_ordy; dt = b_odata; lt = b_olast;
      vl = b_ovalid; bs = b_busy; cn = int'(b_cnt);
    end
  endtask

  task automatic cmp_inst(input int i);
    logic [3:0] v, l, g, rd;
    logic [31:0] d;
    logic r, lt, vl, bs;
    logic [7:0] dt;
    int cn, own, eg, ev, src;
    get_in(i, v, l, d, r);
    get_out(i, g, rd, dt, lt, vl, bs, cn);
    own = m_own[i];
    eg  = (own >= 0) ? (1 << own) : 0;
    ev  = (own >= 0) ? int'(v[own]) : 0;
    chk($sformatf("u%0d_grant", i), int'(g), eg);
    chk($sformatf("u%0d_busy", i), int'(bs), (own >= 0) ? 1 : 0);
    chk($sformatf("u%0d_valid", i), int'(vl), ev);
    chk($sformatf("u%0d_ready", i), int'(rd), (own >= 0 && r) ? eg : 0);
    chk($sformatf("u%0d_cnt", i), cn, m_cnt[i]);
    if (ev != 0) begin
      chk($sformatf("u%0d_data", i), int'(dt), int'(d[own*8 +: 8]));
      chk($sformatf("u%0d_last", i), int'(lt), int'(l[own]));
    end
    if (vl && r) begin
      src = 0;
      for (int k = 0; k < 4; k++) if (g[k]) src = k;
      logq[i].push_back(src * 512 + int'(lt) * 256 + int'(dt));
    end
    if (ev != 0 && r) pop_req[i*4 + own] = 1'b1;
  endtask

  task automatic model_update(input int i);
    logic [3:0] v, l;
    logic [31:0] d;
    logic r;
    int k;
    bit found;
    get_in(i, v, l, d, r);
    if (!rst_n) begin
      m_own[i] = -1; m_ptr[i] = 0; m_cnt[i] = 0;
    end else if (m_own[i] < 0) begin
      found = 0;
      for (int j = 0; j < m_n[i]; j++) begin
        k = (m_ptr[i] + j) % m_n[i];
        if (!found && v[k]) begin
          found = 1;
          m_own[i] = k;
        end
      end
    end else if (v[m_own[i]] && r && l[m_own[i]]) begin
      m_ptr[i] = (m_own[i] + 1) % m_n[i];
      m_own[i] = -1;
      m_cnt[i] = (m_cnt[i] + 1) % m_mod[i];
    end
  endtask

  task automatic step();
    drive_inputs();
    for (int k = 0; k < 8; k++) pop_req[k] = 1'b0;
    @(negedge i_clk);
    cmp_inst(0);
    cmp_inst(1);
    @(posedge i_clk);
    model_update(0);
    model_update(1);
    #1;
    for (int k = 0; k < 8; k++) if (pop_req[k] && srcq[k].size() != 0) void'(srcq[k].pop_front());
  endtask

  function automatic bit pending();
    for (int k = 0; k < 8; k++) if (srcq[k].size() != 0) return 1'b1;
    for (int k = 0; k < 2; k++) if (m_own[k] >= 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_idle(input int bound, output int steps);
    steps = 0;
    do begin
      step();
      steps++;
    end while (pending() && steps < bound);
    if (pending()) chk("idle_timeout", 1, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 8; k++) srcq[k].delete();
    step();
    rst_n = 1'b1;
    logq[0].delete();
    logq[1].delete();
  endtask

  task automatic chk_log(input int i, input int idx, input int exp);
    if (idx >= logq[i].size()) chk($sformatf("u%0d_log_len", i), logq[i].size(), idx + 1);
    else chk($sformatf("u%0d_log%0d", i, idx), logq[i][idx], exp);
  endtask

  int n;
  int s;
  int cnt_seq[5] = '{1, 2, 3, 0, 1};

  initial begin
    rst_n = 1'b0;
    a_ready_in = 1'b1;
    b_ready_in = 1'b1;
    a_data = '0; a_last = '0; a_valid = '0;
    b_data = '0; b_last = '0; b_valid = '0;

    // Reset state
    do_reset();
    chk("rst_grant", int'(a_grant), 0);
    chk("rst_valid", int'(a_ovalid), 0);
    chk("rst_ready", int'(a_ordy), 0);
    chk("rst_cnt", int'(a_cnt), 0);

    // Basic 3-beat transfer from source 0
    srcq[0].push_back(9'h041); srcq[0].push_back(9'h042); srcq[0].push_back(9'h143);
    step();
    chk("basic_grant", int'(a_grant), 1);
    chk("basic_busy", int'(a_busy), 1);
    run_idle(20, n);
    chk("basic_beats_cycles", n, 3);
    chk_log(0, 0, 'h041); chk_log(0, 1, 'h042); chk_log(0, 2, 'h143);
    chk("basic_cnt", int'(a_cnt), 1);
    chk("basic_ptr", m_ptr[0], 1);
    chk("basic_idle_grant", int'(a_grant), 0);

    // Contention: two 2-beat packets per source, strict alternation with one bubble each
    do_reset();
    srcq[0].push_back(9'h010); srcq[0].push_back(9'h111);
    srcq[0].push_back(9'h012); srcq[0].push_back(9'h113);
    srcq[1].push_back(9'h020); srcq[1].push_back(9'h121);
    srcq[1].push_back(9'h022); srcq[1].push_back(9'h123);
    run_idle(40, n);
    chk("cont_cycles", n, 12);
    chk_log(0, 0, 'h010); chk_log(0, 1, 'h111); chk_log(0, 2, 'h220); chk_log(0, 3, 'h321);
    chk_log(0, 4, 'h012); chk_log(0, 5, 'h113); chk_log(0, 6, 'h222); chk_log(0, 7, 'h323);
    chk("cont_cnt", int'(a_cnt), 4);

    // Backpressure: i_ready pattern 1,0,0,1 repeating during a 4-beat packet
    do_reset();
    srcq[0].push_back(9'h0A0); srcq[0].push_back(9'h0A1);
    srcq[0].push_back(9'h0A2); srcq[0].push_back(9'h1A3);
    s = 0;
    do begin
      a_ready_in = (s % 4 == 0) || (s % 4 == 3);
      step();
      s++;
    end while (pending() && s < 40);
    if (pending()) chk("bp_timeout", 1, 0);
    a_ready_in = 1'b1;
    chk("bp_cycles", s, 9);
    chk("bp_nbeats", logq[0].size(), 4);
    chk_log(0, 0, 'h0A0); chk_log(0, 1, 'h0A1); chk_log(0, 2, 'h0A2); chk_log(0, 3, 'h1A3);

    // Wrap, N=4: source 2 then sources 0 and 3 together
    do_reset();
    srcq[6].push_back(9'h152);
    run_idle(10, n);
    chk("wrap_ptr3", m_ptr[1], 3);
    srcq[4].push_back(9'h150);
    srcq[7].push_back(9'h153);
    run_idle(10, n);
    chk_log(1, 0, 'h552); chk_log(1, 1, 'h753); chk_log(1, 2, 'h150);
    chk("wrap_ptr1", m_ptr[1], 1);
    chk("wrap_cnt", int'(b_cnt), 3);

    // Reset mid-packet after beat 2 of 5
    do_reset();
    for (int k = 0; k < 5; k++) srcq[0].push_back({(k == 4) ? 1'b1 : 1'b0, 8'(8'h30 + k)});
    s = 0;
    do begin
      step();
      s++;
    end while (logq[0].size() < 2 && s < 10);
    chk("mid_beats_before", logq[0].size(), 2);
    rst_n = 1'b0;
    srcq[0].delete();
    step();
    rst_n = 1'b1;
    chk("mid_valid", int'(a_ovalid), 0);
    chk("mid_grant", int'(a_grant), 0);
    chk("mid_cnt", int'(a_cnt), 0);
    srcq[0].push_back(9'h170);
    srcq[1].push_back(9'h171);
    run_idle(10, n);
    chk_log(0, 0, 'h030); chk_log(0, 1, 'h031); chk_log(0, 2, 'h170); chk_log(0, 3, 'h371);
    chk("mid_len", logq[0].size(), 4);

    // Counter wrap, CW=2: five single-beat packets from u1 source 1
    do_reset();
    for (int p = 0; p < 5; p++) begin
      srcq[5].push_back({1'b1, 8'(8'h60 + p)});
      run_idle(10, n);
      chk($sformatf("cw_cycles%0d", p), n, 2);
      chk($sformatf("cw_cnt%0d", p), int'(b_cnt), cnt_seq[p]);
    end
    chk_log(1, 4, 'h364);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
